// File: rtl/branch_predict_unit.sv
// Direct-mapped 2-bit-counter branch predictor with ID/EX in-flight tracking,
// EX-stage misprediction detection, redirect/flush generation and table training.
module branch_predict_unit #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  if_pc,
  input  logic             stall,
  input  logic             ex_branch,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  ex_target,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int          TAG_W   = PC_W - IDX_W - 2;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_t;

  typedef struct packed {
    logic            v;
    logic [PC_W-1:0] pc;
    logic            pt;
    logic [PC_W-1:0] ptgt;
  } rec_t;

  logic             tbl_valid  [ENTRIES];
  logic [TAG_W-1:0] tbl_tag    [ENTRIES];
  logic [PC_W-1:0]  tbl_target [ENTRIES];
  cnt_t             tbl_cnt    [ENTRIES];

  rec_t id_q;
  rec_t ex_q;

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             mispredict;

  function automatic cnt_t cnt_next(input cnt_t c, input logic up);
    cnt_t n;
    n = c;
    case (c)
      CNT_SNT: n = up ? CNT_WNT : CNT_SNT;
      CNT_WNT: n = up ? CNT_WT  : CNT_SNT;
      CNT_WT:  n = up ? CNT_ST  : CNT_WNT;
      CNT_ST:  n = up ? CNT_ST  : CNT_WT;
      default: n = CNT_SNT;
    endcase
    return n;
  endfunction

  // Fetch-side lookup
  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign if_hit = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);

  always_comb begin
    pred_taken  = if_hit && tbl_cnt[if_idx][1];
    pred_target = '0;
    if (pred_taken) begin
      pred_target = tbl_target[if_idx];
    end
  end

  // EX-side lookup of the resolving instruction, used for training
  assign ex_idx = ex_q.pc[IDX_W+1:2];
  assign ex_tag = ex_q.pc[PC_W-1:IDX_W+2];
  assign ex_hit = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_tag);

  always_comb begin
    mispredict = 1'b0;
    if (ex_q.v) begin
      if (ex_branch) begin
        if (ex_taken != ex_q.pt) begin
          mispredict = 1'b1;
        end else if (ex_taken && (ex_target != ex_q.ptgt)) begin
          mispredict = 1'b1;
        end
      end else begin
        mispredict = ex_q.pt;
      end
    end
  end

  always_comb begin
    redirect    = mispredict;
    redirect_pc = '0;
    if (mispredict) begin
      if (ex_branch && ex_taken) begin
        redirect_pc = ex_target;
      end else begin
        redirect_pc = ex_q.pc + PC_W'(4);
      end
    end
  end

  // In-flight records: redirect flushes both, stall holds ID and bubbles EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q <= '0;
      ex_q <= '0;
    end else if (redirect) begin
      id_q <= '0;
      ex_q <= '0;
    end else if (stall) begin
      ex_q <= '0;
    end else begin
      id_q <= {1'b1, if_pc, pred_taken, pred_target};
      ex_q <= id_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_tag[i]    <= '0;
        tbl_target[i] <= '0;
        tbl_cnt[i]    <= CNT_SNT;
      end
    end else if (ex_q.v) begin
      if (ex_branch) begin
        if (ex_hit) begin
          tbl_cnt[ex_idx] <= cnt_next(tbl_cnt[ex_idx], ex_taken);
          if (ex_taken) begin
            tbl_target[ex_idx] <= ex_target;
          end
        end else if (ex_taken) begin
          tbl_valid[ex_idx]  <= 1'b1;
          tbl_tag[ex_idx]    <= ex_tag;
          tbl_target[ex_idx] <= ex_target;
          tbl_cnt[ex_idx]    <= CNT_WT;
        end
      end else if (ex_hit) begin
        // A non-branch hitting the table means the entry is stale
        tbl_valid[ex_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_cnt <= '0;
    end else if (redirect && (mispredict_cnt != '1)) begin
      mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Dynamic branch predictor and misprediction recovery for the 5-stage pipeline. Looks up the fetch PC in a direct-mapped table of 2-bit saturating counters with targets and issues a taken/not-taken prediction in IF. It tracks each prediction through ID to EX, where it compares the prediction against the resolved beq/bne outcome. On a mismatch it raises a one-cycle redirect/flush and trains the table.

## Interface
- PC_W, 32, PC width in bits.
- IDX_W, 4, index bits; the table has 2^IDX_W entries.
- CNT_W, 16, width of the mispredict statistics counter.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_pc  in  PC_W  PC currently in fetch; word-aligned.
- stall  in  1  load-use stall. IF/ID hold, and EX receives a bubble.
- ex_branch  in  1  the instruction in EX is beq/bne.
- ex_taken  in  1  resolved branch condition from the branch-decision logic.
- ex_target  in  PC_W  computed branch target in EX.
- pred_taken  out  1  prediction for if_pc (combinational).
- pred_target  out  PC_W  predicted target for if_pc; 0 when pred_taken=0.
- redirect  out  1  misprediction in EX this cycle; also the IF/ID/EX flush request.
- redirect_pc  out  PC_W  correct next PC when redirect=1; 0 otherwise.
- mispredict_cnt  out  CNT_W  saturating count of redirects.

## Operation
- **Table entry fields:** valid, tag = pc[PC_W-1:IDX_W+2], target, 2-bit counter.
  - Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- **Index:** pc[IDX_W+1:2].
- **Lookup (IF):**
  - hit = valid & tag match.
  - pred_taken = hit & cnt[1].
  - pred_target = the entry's target when pred_taken=1, else 0.
- **In-flight records, ID and EX:** each holds {v, pc, pred_taken, pred_target}.
  - stall=0: ID <= {1, if_pc, pred}, and EX <= ID.
  - stall=1: ID holds, and EX <= invalid.
  - redirect=1: ID and EX <= invalid. This overrides stall.
- **Mispredict** (evaluated only when EX.v=1); any one of these holds:
  - ex_branch & (ex_taken != EX.pred_taken).
  - ex_branch & ex_taken & EX.pred_taken & (ex_target != EX.pred_target).
  - ~ex_branch & EX.pred_taken (stale entry).
- **redirect_pc:**
  - ex_taken & ex_branch: ex_target.
  - otherwise: EX.pc + 4, modulo 2^PC_W.
- **Training** (EX.v=1, at the clock edge):
  - ex_branch & hit: counter increments on taken and decrements on not-taken, saturating at 11/00. The target is overwritten with ex_target when taken.
  - ex_branch & miss & ex_taken: allocate, replacing any existing entry. The entry is valid with EX.pc's tag, target=ex_target, cnt=10.
  - ex_branch & miss & ~ex_taken: no change.
  - ~ex_branch & hit: invalidate the entry.
- **mispredict_cnt:** +1 on each cycle with redirect=1; holds at all-ones.

## Timing
- Lookup is combinational from if_pc, in the same cycle.
- Prediction to resolution is 2 cycles, absent stalls.
- redirect is combinational from the EX record and ex_* inputs.
  - It is high for exactly one cycle per mispredicting instruction.
  - EX is invalid in the following cycle, so redirect cannot repeat.
- A table write is visible to lookups starting the next cycle. There is no same-cycle bypass: a lookup hitting the index being trained sees the old contents.
- Reset (asynchronous, any time including mid-redirect):
  - all valid bits = 0; ID and EX invalid; counters and targets = 0; mispredict_cnt = 0.
  - Therefore pred_taken=0, pred_target=0, redirect=0 and redirect_pc=0 while rst_n=0 and on the first cycle after.
- A stall and a redirect in the same cycle: redirect wins, and both records are cleared.
- ex_* inputs are ignored when EX.v=0; no training or counting occurs.

## Test plan
- **Reset:** rst_n=0 mid-run → all outputs 0. First branch at PC 0x40, taken to 0x80 → redirect=1, redirect_pc=0x80, mispredict_cnt=1. Entry 0 then holds cnt=10 and target 0x80.
- **Saturation:** same branch taken 3 more times → no redirect. Then not-taken → redirect_pc=0x44 with cnt 11→10. A second not-taken → redirect again, cnt=01. The following lookup gives pred_taken=0.
- **Alias:** PC 0x40 is resident. A taken branch at 0x440 (same index, different tag) → miss, redirect, and the entry is replaced. A subsequent lookup of 0x40 → pred_taken=0.
- **Stale entry:** a non-branch at a hit PC predicted taken → redirect_pc=pc+4, and the entry is invalidated.
- **Stall and bubble:** stall=1 for 2 cycles while a predicted branch is in ID → EX is a bubble with no training. The branch resolves 2 cycles late with the correct PC.
- **Priority and counter limits:**
  - redirect with stall=1 in the same cycle → ID and EX invalid next cycle.
  - Force CNT_W=4 and 20 mispredicts → mispredict_cnt=0xF.
